keyevent_fifo: RTL and testbench



---
 rtl/keyevent_fifo_if.sv | 27 ++
 rtl/keyevent_fifo.sv | 195 +++++++++++++++++++
 tb/tb_keyevent_fifo.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/keyevent_fifo_if.sv
// Wishbone slave bus bundle for the key-event FIFO.
interface keyevent_fifo_if;
    logic [2:0]  wb_addr;
    logic [31:0] wb_rdata;
    logic [31:0] wb_wdata;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;

    modport master (
        output wb_addr,
        output wb_wdata,
        output wb_we,
        output wb_cyc,
        input  wb_rdata,
        input  wb_ack
    );

    modport slave (
        input  wb_addr,
        input  wb_wdata,
        input  wb_we,
        input  wb_cyc,
        output wb_rdata,
        output wb_ack
    );
endinterface

// File: rtl/keyevent_fifo.sv
// Key-event FIFO: scans the debounced key matrix one key per cycle, queues press/release
// events and lets firmware drain them over Wishbone, with an optional pending-event interrupt.
module keyevent_fifo #(
    parameter int unsigned N_ROWS     = 4,
    parameter int unsigned N_COLS     = 12,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_ROWS*N_COLS-1:0] key_state,
    keyevent_fifo_if.slave           bus,
    output logic                     irq
);
    localparam int unsigned NKeys = N_ROWS * N_COLS;
    localparam int unsigned IdxW  = (NKeys > 1) ? $clog2(NKeys) : 1;
    localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LvlW  = PtrW + 1;

    // Scanner state
    logic [NKeys-1:0] prev_q, prev_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [1:0]       row_q, row_d;
    logic [3:0]       col_q, col_d;

    // Control / status
    logic enable_q, enable_d;
    logic irq_en_q, irq_en_d;
    logic overflow_q, overflow_d;

    // FIFO
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;

    // Bus side
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;
    logic        wr_stb_q, wr_stb_d;
    logic        wr_sel_q, wr_sel_d;
    logic [2:0]  wr_bits_q, wr_bits_d;   // {clear overflow, irq_en, enable}

    logic        key_bit, changed, push, pop, ovf_set, empty, full;
    logic [7:0]  event_byte, head;
    logic [31:0] status_word, event_word, level_ext;

    assign empty = (level_q == '0);
    // Full is taken before any same-cycle pop, so a push is refused at level FIFO_DEPTH.
    assign full  = (level_q == LvlW'(FIFO_DEPTH));
    assign head  = mem_q[rd_ptr_q];

    // Scanner: compare one key per cycle against its last reported state.
    always_comb begin
        key_bit    = key_state[idx_q];
        changed    = key_bit ^ prev_q[idx_q];
        push       = enable_q & changed & ~full;
        ovf_set    = enable_q & changed & full;
        event_byte = {key_bit, 1'b0, row_q, col_q};
        prev_d     = prev_q;
        idx_d      = idx_q;
        row_d      = row_q;
        col_d      = col_q;
        if (!enable_q) begin
            // Track the live state while disabled so re-enabling emits nothing stale.
            prev_d = key_state;
            idx_d  = '0;
            row_d  = '0;
            col_d  = '0;
        end else begin
            if (push) begin
                prev_d[idx_q] = key_bit;
            end
            if (idx_q == IdxW'(NKeys - 1)) begin
                idx_d = '0;
                row_d = '0;
                col_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
                if (col_q == 4'(N_COLS - 1)) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    // Wishbone decode: single-cycle ack, registered read data, registered write strobe.
    always_comb begin
        level_ext   = 32'(level_q);
        status_word = 32'd0;
        status_word[0]     = enable_q;
        status_word[1]     = irq_en_q;
        status_word[8]     = overflow_q;
        status_word[9]     = empty;
        status_word[20:16] = level_ext[4:0];
        event_word  = {~empty, 23'd0, empty ? 8'd0 : head};

        ack_d     = bus.wb_cyc & ~ack_q;
        wr_stb_d  = bus.wb_cyc & bus.wb_we & ~ack_q;
        wr_sel_d  = bus.wb_addr[0];
        wr_bits_d = {bus.wb_wdata[8], bus.wb_wdata[1], bus.wb_wdata[0]};
        // Pop only on the load cycle of a read, so each transaction pops at most once.
        pop       = bus.wb_cyc & ~ack_q & ~bus.wb_we & bus.wb_addr[0] & ~empty;
        rdata_d   = 32'd0;
        if (bus.wb_cyc && !ack_q) begin
            rdata_d = bus.wb_addr[0] ? event_word : status_word;
        end
        irq_d = irq_en_q & ~empty;
    end

    // Control register writes; a same-cycle overflow set beats the clear.
    always_comb begin
        enable_d   = enable_q;
        irq_en_d   = irq_en_q;
        overflow_d = overflow_q;
        if (wr_stb_q && !wr_sel_q) begin
            enable_d = wr_bits_q[0];
            irq_en_d = wr_bits_q[1];
            if (wr_bits_q[2]) begin
                overflow_d = 1'b0;
            end
        end
        if (ovf_set) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO pointer and level bookkeeping.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= '0;
            idx_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ack_q      <= 1'b0;
            rdata_q    <= 32'd0;
            irq_q      <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_sel_q   <= 1'b0;
            wr_bits_q  <= '0;
        end else begin
            prev_q     <= prev_d;
            idx_q      <= idx_d;
            row_q      <= row_d;
            col_q      <= col_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
            wr_stb_q   <= wr_stb_d;
            wr_sel_q   <= wr_sel_d;
            wr_bits_q  <= wr_bits_d;
        end
    end

    // Event storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= event_byte;
        end
    end

    assign bus.wb_ack   = ack_q;
    assign bus.wb_rdata = rdata_q;
    assign irq          = irq_q;

    logic unused_bits;
    assign unused_bits = ^{bus.wb_addr[2:1], bus.wb_wdata[31:9], bus.wb_wdata[7:2],
                           level_ext[31:5]};
endmodule

// File: tb/tb_keyevent_fifo.sv
// Scoreboard bench for keyevent_fifo: stimulus queues expectations, a monitor checks them.
module tb_keyevent_fifo;
    localparam int unsigned NKeys = 48;

    logic             clk = 1'b0;
    logic             rst;
    logic [NKeys-1:0] key_state;
    logic             irq;

    keyevent_fifo_if bus ();

    keyevent_fifo #(
        .N_ROWS     (4),
        .N_COLS     (12),
        .FIFO_DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_state (key_state),
        .bus       (bus),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic [31:0] exp;
        string       name;
    } rd_t;

    typedef struct {
        logic [31:0] act;
        logic [31:0] exp;
        string       name;
    } aux_t;

    rd_t  rd_q[$];
    aux_t aux_q[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: compare read data on every ack, then drain sampled side checks.
    always @(negedge clk) begin
        rd_t  r;
        aux_t a;
        if (bus.wb_ack === 1'b1) begin
            if (rd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack=1 want no pending access");
            end else begin
                r = rd_q.pop_front();
                if (r.chk) begin
                    total++;
                    if (bus.wb_rdata !== r.exp) begin
                        bad++;
                        $display("FAIL %s: got %08h want %08h", r.name, bus.wb_rdata, r.exp);
                    end
                end
            end
        end
        while (aux_q.size() != 0) begin
            a = aux_q.pop_front();
            total++;
            if (a.act !== a.exp) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", a.name, a.act, a.exp);
            end
        end
    end

    task automatic check(input logic [31:0] act, input logic [31:0] exp, input string name);
        aux_t a;
        a.act  = act;
        a.exp  = exp;
        a.name = name;
        aux_q.push_back(a);
    endtask

    task automatic bus_access(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                              input logic chk, input logic [31:0] exp, input string name,
                              output int lat);
        rd_t r;
        r.chk  = chk;
        r.exp  = exp;
        r.name = name;
        rd_q.push_back(r);
        bus.wb_cyc   = 1'b1;
        bus.wb_we    = we;
        bus.wb_addr  = addr;
        bus.wb_wdata = wdata;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (bus.wb_ack !== 1'b1 && lat < 8);
        if (bus.wb_ack !== 1'b1) begin
            r = rd_q.pop_back();
            check(32'd0, 32'd1, {name, "_ack_timeout"});
        end
        bus.wb_cyc = 1'b0;
        bus.wb_we  = 1'b0;
    endtask

    task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string name);
        int lat;
        bus_access(1'b0, addr, 32'd0, 1'b1, exp, name, lat);
    endtask

    // Returns one cycle after ack so the written control value is already in effect.
    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        int lat;
        bus_access(1'b1, addr, data, 1'b0, 32'd0, "write", lat);
        @(posedge clk);
        #1;
    endtask

    logic [7:0] drain_exp [16] = '{8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89,
                                   8'h8A, 8'h8B, 8'h90, 8'h91, 8'h92, 8'h93, 8'h94, 8'h95};

    initial begin
        int lat;
        int n;
        rst          = 1'b1;
        key_state    = '0;
        bus.wb_cyc   = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check({31'd0, irq}, 32'd0, "irq_after_reset");
        bus_access(1'b0, 3'd0, 32'd0, 1'b1, 32'h0000_0200, "status_reset", lat);
        check(lat, 32'd1, "ack_latency");
        rd(3'd1, 32'h0000_0000, "event_reset_empty");

        // Single press / release of row2 col5
        wr(3'd0, 32'h1);
        key_state[29] = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        rd(3'd0, 32'h0001_0001, "status_level1");
        rd(3'd1, 32'h8000_00A5, "ev_press_r2c5");
        rd(3'd1, 32'h0000_0000, "ev_after_pop");
        key_state[29] = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rd(3'd1, 32'h8000_0025, "ev_release_r2c5");

        // Interrupt behaviour
        wr(3'd0, 32'h3);
        key_state[0] = 1'b1;
        n = 0;
        while (irq !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({31'd0, irq}, 32'd1, "irq_rise");
        rd(3'd0, 32'h0001_0003, "status_irq_en");
        rd(3'd1, 32'h8000_0080, "ev_press_k0");
        check({31'd0, irq}, 32'd1, "irq_hold_pop_cycle");
        @(posedge clk);
        #1;
        check({31'd0, irq}, 32'd0, "irq_fall");
        wr(3'd0, 32'h1);
        key_state[0] = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check({31'd0, irq}, 32'd0, "irq_masked");
        rd(3'd0, 32'h0001_0001, "status_masked_level1");
        rd(3'd1, 32'h8000_0000, "ev_release_k0");

        // Overflow: 17 simultaneous presses from a freshly restarted sweep
        wr(3'd0, 32'h0);
        wr(3'd0, 32'h1);
        key_state[17:1] = '1;
        repeat (50) @(posedge clk);
        #1;
        rd(3'd0, 32'h0010_0101, "status_full_ovf");
        rd(3'd1, 32'h8000_0081, "ev_first_of_17");
        repeat (50) @(posedge clk);
        #1;
        rd(3'd0, 32'h0010_0101, "status_refilled");
        wr(3'd0, 32'h101);
        rd(3'd0, 32'h0010_0001, "status_ovf_cleared");
        for (int i = 0; i < 16; i++) begin
            rd(3'd1, {24'h80_0000, drain_exp[i]}, $sformatf("drain_%0d", i));
        end
        rd(3'd1, 32'h0000_0000, "ev_drained_empty");

        // Disabled scanner ignores changes; re-enable emits nothing stale
        wr(3'd0, 32'h0);
        key_state[0]  = ~key_state[0];
        key_state[5]  = ~key_state[5];
        key_state[47] = ~key_state[47];
        repeat (10) @(posedge clk);
        #1;
        rd(3'd0, 32'h0000_0200, "status_disabled");
        wr(3'd0, 32'h1);
        repeat (200) @(posedge clk);
        #1;
        rd(3'd0, 32'h0000_0201, "status_reenabled");
        check({31'd0, irq}, 32'd0, "irq_reenabled");

        // Reset during a read discards queued events
        key_state[22:20] = 3'b111;
        repeat (50) @(posedge clk);
        #1;
        rd(3'd0, 32'h0003_0001, "status_three_queued");
        bus.wb_cyc  = 1'b1;
        bus.wb_we   = 1'b0;
        bus.wb_addr = 3'd1;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        check({31'd0, bus.wb_ack}, 32'd0, "ack_aborted_by_rst");
        rst        = 1'b0;
        bus.wb_cyc = 1'b0;
        @(posedge clk);
        #1;
        rd(3'd0, 32'h0000_0200, "status_after_rst");
        check({31'd0, irq}, 32'd0, "irq_after_rst");

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
